// File: rtl/hls_perf_mon_pkg.sv
// Shared types and helpers for the HLS handshake performance monitor.
// Stat select encoding and a width-generic saturating increment.
package hls_perf_mon_pkg;

    localparam int unsigned SEL_W     = 3;
    localparam int unsigned MAX_CNT_W = 64;

    typedef enum logic [SEL_W-1:0] {
        SelStartCnt = 3'd0,
        SelDoneCnt  = 3'd1,
        SelLatLast  = 3'd2,
        SelLatMin   = 3'd3,
        SelLatMax   = 3'd4,
        SelIiLast   = 3'd5,
        SelStallCnt = 3'd6,
        SelBusyCnt  = 3'd7
    } perf_sel_e;

    // Counter of the given width held in the low bits; sticks at all-ones.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                      input int unsigned width);
        logic [MAX_CNT_W-1:0] max_val;
        max_val = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - width);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/hls_ts_fifo.sv
// Small timestamp FIFO holding start times of outstanding transactions.
// Push while full is dropped unless a pop happens in the same cycle.
module hls_ts_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth) + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                     (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q[PtrW-2:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-2:0]] <= data_i;
    end

endmodule

// File: rtl/hls_handshake_perf_mon.sv
// Per-channel latency / II / stall statistics for HLS ap_ctrl_hs/chain handshakes,
// with a registered indexed read port and sticky overflow/underflow flags.
module hls_handshake_perf_mon
    import hls_perf_mon_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                                          ap_clk,
    input  logic                                          ap_rst_n,
    input  logic                                          mon_en,
    input  logic                                          mon_clr,
    input  logic [NUM_CH-1:0]                             ch_start,
    input  logic [NUM_CH-1:0]                             ch_ready,
    input  logic [NUM_CH-1:0]                             ch_done,
    input  logic [NUM_CH-1:0]                             ch_continue,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    input  logic [SEL_W-1:0]                              rd_sel,
    output logic [CNT_W-1:0]                              rd_data,
    output logic [NUM_CH-1:0]                             ovf_flags,
    output logic [NUM_CH-1:0]                             unf_flags
);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(MAX_CNT_W'(v), CNT_W));
    endfunction

    logic [CNT_W-1:0] ts_q;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] stat [NUM_CH][8];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) ts_q <= '0;
        else           ts_q <= ts_q + CNT_W'(1);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             start_ev, done_ev, stall_ev;
        logic             push, pop, full, empty, lat_upd;
        logic [CNT_W-1:0] head_ts, lat;
        logic [CNT_W-1:0] start_cnt_q, start_cnt_d, done_cnt_q, done_cnt_d;
        logic [CNT_W-1:0] lat_last_q, lat_last_d, lat_min_q, lat_min_d, lat_max_q, lat_max_d;
        logic [CNT_W-1:0] ii_last_q, ii_last_d, stall_cnt_q, stall_cnt_d;
        logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d, prev_ts_q, prev_ts_d;
        logic             seen_q, seen_d, ovf_q, ovf_d, unf_q, unf_d;

        assign start_ev = ch_start[g] & ch_ready[g];
        assign done_ev  = ch_done[g] & ch_continue[g];
        assign stall_ev = ch_done[g] & ~ch_continue[g];

        // Start+done on an empty FIFO is a zero-latency pass-through: nothing is queued.
        assign push    = mon_en & ~mon_clr & start_ev & ~(empty & done_ev);
        assign pop     = mon_en & ~mon_clr & done_ev & ~empty;
        assign lat_upd = done_ev & (~empty | start_ev);
        assign lat     = empty ? '0 : ts_q - head_ts;

        hls_ts_fifo #(
            .Width (CNT_W),
            .Depth (OUT_DEPTH)
        ) u_fifo (
            .clk_i   (ap_clk),
            .rst_ni  (ap_rst_n),
            .clr_i   (mon_clr),
            .push_i  (push),
            .pop_i   (pop),
            .data_i  (ts_q),
            .data_o  (head_ts),
            .full_o  (full),
            .empty_o (empty)
        );

        always_comb begin
            start_cnt_d = start_cnt_q;
            done_cnt_d  = done_cnt_q;
            lat_last_d  = lat_last_q;
            lat_min_d   = lat_min_q;
            lat_max_d   = lat_max_q;
            ii_last_d   = ii_last_q;
            stall_cnt_d = stall_cnt_q;
            busy_cnt_d  = busy_cnt_q;
            prev_ts_d   = prev_ts_q;
            seen_d      = seen_q;
            ovf_d       = ovf_q;
            unf_d       = unf_q;
            if (mon_clr) begin
                start_cnt_d = '0;
                done_cnt_d  = '0;
                lat_last_d  = '0;
                lat_min_d   = '1;
                lat_max_d   = '0;
                ii_last_d   = '0;
                stall_cnt_d = '0;
                busy_cnt_d  = '0;
                prev_ts_d   = '0;
                seen_d      = 1'b0;
                ovf_d       = 1'b0;
                unf_d       = 1'b0;
            end else if (mon_en) begin
                if (start_ev) begin
                    start_cnt_d = inc(start_cnt_q);
                    if (seen_q) ii_last_d = ts_q - prev_ts_q;
                    prev_ts_d = ts_q;
                    seen_d    = 1'b1;
                    if (full && !done_ev) ovf_d = 1'b1;
                end
                if (done_ev) begin
                    done_cnt_d = inc(done_cnt_q);
                    if (empty && !start_ev) unf_d = 1'b1;
                end
                if (lat_upd) begin
                    lat_last_d = lat;
                    if (lat < lat_min_q) lat_min_d = lat;
                    if (lat > lat_max_q) lat_max_d = lat;
                end
                if (stall_ev) stall_cnt_d = inc(stall_cnt_q);
                if (!empty)   busy_cnt_d  = inc(busy_cnt_q);
            end
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                start_cnt_q <= '0;
                done_cnt_q  <= '0;
                lat_last_q  <= '0;
                lat_min_q   <= '1;
                lat_max_q   <= '0;
                ii_last_q   <= '0;
                stall_cnt_q <= '0;
                busy_cnt_q  <= '0;
                prev_ts_q   <= '0;
                seen_q      <= 1'b0;
                ovf_q       <= 1'b0;
                unf_q       <= 1'b0;
            end else begin
                start_cnt_q <= start_cnt_d;
                done_cnt_q  <= done_cnt_d;
                lat_last_q  <= lat_last_d;
                lat_min_q   <= lat_min_d;
                lat_max_q   <= lat_max_d;
                ii_last_q   <= ii_last_d;
                stall_cnt_q <= stall_cnt_d;
                busy_cnt_q  <= busy_cnt_d;
                prev_ts_q   <= prev_ts_d;
                seen_q      <= seen_d;
                ovf_q       <= ovf_d;
                unf_q       <= unf_d;
            end
        end

        assign stat[g][SelStartCnt] = start_cnt_q;
        assign stat[g][SelDoneCnt]  = done_cnt_q;
        assign stat[g][SelLatLast]  = lat_last_q;
        assign stat[g][SelLatMin]   = lat_min_q;
        assign stat[g][SelLatMax]   = lat_max_q;
        assign stat[g][SelIiLast]   = ii_last_q;
        assign stat[g][SelStallCnt] = stall_cnt_q;
        assign stat[g][SelBusyCnt]  = busy_cnt_q;
        assign ovf_flags[g]         = ovf_q;
        assign unf_flags[g]         = unf_q;
    end

    always_comb begin
        rd_data_d = '0;
        if (32'(rd_ch) < NUM_CH) rd_data_d = stat[rd_ch][rd_sel];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rd_data_q <= '0;
        else           rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule
